group_mac_sequencer: RTL and testbench

//  Sequencer for one 8-MAC grouped column. Per job: latches one weight beat, streams vec_len

---
 rtl/group_mac_pkg.sv | 16 +
 rtl/mac_skew_buffer.sv | 29 ++
 rtl/group_mac_sequencer.sv | 132 +++++++++++++
 tb/tb_group_mac_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/group_mac_pkg.sv
// Shared types and widths for the grouped MAC column sequencer.
package group_mac_pkg;

  localparam int unsigned N_MAC  = 8;
  localparam int unsigned ACT_W  = 8;
  localparam int unsigned PSUM_W = 24;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/mac_skew_buffer.sv
// Per-lane input skew for the MAC column: lane k sees its activation k+1 cycles after issue.
module mac_skew_buffer
  import group_mac_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   issue,
  input  logic [N_MAC*ACT_W-1:0] act_in,
  output logic [N_MAC*ACT_W-1:0] act_out
);

  for (genvar k = 0; k < N_MAC; k++) begin : g_lane
    localparam int unsigned DEPTH = k + 1;
    logic [ACT_W-1:0] stage [DEPTH];

    // Zeros enter on non-issue cycles so bubbles contribute nothing downstream.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
        stage[0] <= issue ? act_in[k*ACT_W +: ACT_W] : '0;
        for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign act_out[k*ACT_W +: ACT_W] = stage[DEPTH-1];
  end

endmodule

// File: rtl/group_mac_sequencer.sv
// Job sequencer for one 8-MAC column: weight latch, skewed activation issue,
// in-flight tagging and a first-word-fall-through result FIFO.
module group_mac_sequencer
  import group_mac_pkg::*;
#(
  parameter int unsigned PIPE_LAT   = 9,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LEN_W      = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [LEN_W-1:0]       vec_len,
  output logic                   busy,
  output logic                   done,
  input  logic                   w_valid,
  output logic                   w_ready,
  input  logic [N_MAC*ACT_W-1:0] w_data,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [N_MAC*ACT_W-1:0] a_data,
  output logic [N_MAC*ACT_W-1:0] col_weight,
  output logic [N_MAC*ACT_W-1:0] col_act,
  output logic [PSUM_W-1:0]      col_psum_in,
  output logic [15:0]            col_err_prod_in,
  output logic                   col_err_in,
  input  logic [PSUM_W-1:0]      col_psum_out,
  input  logic                   col_err_out,
  output logic                   r_valid,
  input  logic                   r_ready,
  output logic [PSUM_W-1:0]      r_data,
  output logic                   r_err
);

  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FILL_W = $clog2(FIFO_DEPTH + PIPE_LAT + 1);

  state_t               state, state_nx;
  logic [LEN_W-1:0]     len_q, issued, written;
  logic [PIPE_LAT-1:0]  tags;
  logic                 issue, push, pop;
  logic [FILL_W-1:0]    inflight, occupancy;

  logic [PSUM_W:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;

  assign col_psum_in     = '0;
  assign col_err_prod_in = '0;
  assign col_err_in      = 1'b0;

  // Reserve FIFO space for every tagged vector so a result can always be pushed.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < PIPE_LAT; i++) inflight = inflight + FILL_W'(tags[i]);
    occupancy = FILL_W'(count) + inflight;
  end

  assign a_ready = (state == STREAM) && (occupancy < FILL_W'(FIFO_DEPTH));
  assign issue   = a_valid && a_ready;
  assign w_ready = (state == LOAD_W);
  assign busy    = (state == LOAD_W) || (state == STREAM) || (state == DRAIN);
  assign done    = (state == DONE);
  assign push    = tags[PIPE_LAT-1];
  assign r_valid = (count != '0);
  assign pop     = r_valid && r_ready;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LOAD_W;
      LOAD_W:  if (w_valid) state_nx = (len_q == '0) ? DRAIN : STREAM;
      STREAM:  if (issue && (issued == len_q - LEN_W'(1))) state_nx = DRAIN;
      // Leave as the final result is being pushed so done lines up with it.
      DRAIN:   if ((tags[PIPE_LAT-2:0] == '0) &&
                   ({1'b0, written} + (LEN_W+1)'(push) == {1'b0, len_q}))
                 state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      len_q      <= '0;
      issued     <= '0;
      written    <= '0;
      tags       <= '0;
      col_weight <= '0;
    end else begin
      state <= state_nx;
      tags  <= {tags[PIPE_LAT-2:0], issue};
      if (state == IDLE && start) begin
        len_q   <= vec_len;
        issued  <= '0;
        written <= '0;
      end
      if (issue) issued <= issued + LEN_W'(1);
      if (push) written <= written + LEN_W'(1);
      if (w_valid && w_ready) col_weight <= w_data;
    end
  end

  mac_skew_buffer u_skew (
    .clk     (clk),
    .reset   (reset),
    .issue   (issue),
    .act_in  (a_data),
    .act_out (col_act)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {col_err_out, col_psum_out};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign {r_err, r_data} = mem[rd_ptr];

endmodule

// File: tb/tb_group_mac_sequencer.sv
// Scoreboard bench for group_mac_sequencer with a behavioural systolic MAC column.
module tb_group_mac_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  vec_len = '0;
  logic        busy, done;
  logic        w_valid = 1'b0;
  logic        w_ready;
  logic [63:0] w_data = '0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [63:0] a_data = '0;
  logic [63:0] col_weight, col_act;
  logic [23:0] col_psum_in;
  logic [15:0] col_err_prod_in;
  logic        col_err_in;
  logic [23:0] col_psum_out;
  logic        col_err_out;
  logic        r_valid;
  logic        r_ready = 1'b0;
  logic [23:0] r_data;
  logic        r_err;

  int unsigned checks = 0, errors = 0;

  group_mac_sequencer #(.PIPE_LAT(9), .FIFO_DEPTH(16), .LEN_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .vec_len(vec_len), .busy(busy), .done(done),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .col_weight(col_weight), .col_act(col_act), .col_psum_in(col_psum_in),
    .col_err_prod_in(col_err_prod_in), .col_err_in(col_err_in),
    .col_psum_out(col_psum_out), .col_err_out(col_err_out),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_err(r_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] dot(input logic [63:0] w, input logic [63:0] a);
    logic [23:0] s = '0;
    for (int k = 0; k < 8; k++) s = s + 24'(w[k*8 +: 8]) * 24'(a[k*8 +: 8]);
    return s;
  endfunction

  // Column model: lane k adds w[k]*act[k] to the partial sum from lane k-1.
  logic [23:0] mpsum [8];
  logic [8:0]  merr = '0;
  logic        hs_err = 1'b0;

  always @(posedge clk) begin
    mpsum[0] <= col_psum_in + 24'(col_weight[7:0]) * 24'(col_act[7:0]);
    for (int k = 1; k < 8; k++)
      mpsum[k] <= mpsum[k-1] + 24'(col_weight[k*8 +: 8]) * 24'(col_act[k*8 +: 8]);
    merr <= {merr[7:0], hs_err};
  end
  assign col_psum_out = mpsum[7];
  assign col_err_out  = merr[8];

  logic [24:0] sb [$];
  logic [24:0] ex;
  logic [63:0] w_job = '0;
  int unsigned idx = 0, accepted = 0, results = 0, done_cnt = 0, rv_cycles = 0, sb_at_done = 0;
  int unsigned err_idx = 999;

  always @(negedge clk) begin
    hs_err = 1'b0;
    if (reset) begin
      sb.delete();
      idx = 0;
    end else begin
      if (done) begin
        done_cnt++;
        sb_at_done = sb.size();
      end
      if (w_valid && w_ready) begin
        w_job = w_data;
        idx = 0;
      end
      if (a_valid && a_ready) begin
        hs_err = (idx == err_idx);
        sb.push_back({hs_err, dot(w_job, a_data)});
        idx++;
        accepted++;
      end
      if (r_valid) rv_cycles++;
      if (r_valid && r_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          ex = sb.pop_front();
          check("r_data", 32'(r_data), 32'(ex[23:0]));
          check("r_err", 32'(r_err), 32'(ex[24]));
          results++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [7:0] len, input logic [63:0] w, input bit hold);
    bit ok;
    start = 1'b1;
    vec_len = len;
    tick();
    if (!hold) start = 1'b0;
    w_valid = 1'b1;
    w_data = w;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (w_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("w_ready_timeout", 32'(w_ready), 32'd1);
    tick();
    w_valid = 1'b0;
  endtask

  task automatic send_vectors(input int n, input bit toggle, input bit rnd, input logic [63:0] pat);
    bit ok;
    for (int i = 0; i < n; i++) begin
      a_valid = 1'b1;
      a_data = rnd ? {$urandom, $urandom} : pat;
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (a_ready) begin ok = 1'b1; break; end
      end
      if (!ok) check("a_ready_timeout", 32'(a_ready), 32'd1);
      tick();
      if (toggle) begin
        a_valid = 1'b0;
        tick();
      end
    end
    a_valid = 1'b0;
  endtask

  task automatic wait_done(input int max);
    for (int c = 0; c < max; c++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  task automatic wait_empty(input int max);
    for (int c = 0; c < max; c++) begin
      @(negedge clk);
      if (sb.size() == 0 && !r_valid && !busy) break;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_w_ready"}, 32'(w_ready), 32'd0);
    check({tag, "_a_ready"}, 32'(a_ready), 32'd0);
    check({tag, "_r_valid"}, 32'(r_valid), 32'd0);
    check({tag, "_col_weight"}, 32'(col_weight != '0), 32'd0);
    check({tag, "_col_act"}, 32'(col_act != '0), 32'd0);
    check({tag, "_r_data"}, 32'(r_data), 32'd0);
  endtask

  int unsigned d0, r0, a0, v0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    reset = 1'b0;
    tick();
    r_ready = 1'b1;

    // Reset mid-stream after three issues.
    d0 = done_cnt;
    start_job(8'd10, {$urandom, $urandom}, 1'b0);
    send_vectors(3, 1'b0, 1'b1, '0);
    reset = 1'b1;
    tick();
    tick();
    check_quiet("abort");
    reset = 1'b0;
    v0 = rv_cycles;
    repeat (15) tick();
    check("abort_no_done", done_cnt, d0);
    check("abort_no_result", rv_cycles, v0);
    check("abort_busy", 32'(busy), 32'd0);

    // Unit weights and acts of 2 give 16 per vector.
    d0 = done_cnt; r0 = results;
    start_job(8'd4, {8{8'h01}}, 1'b0);
    send_vectors(4, 1'b0, 1'b0, {8{8'h02}});
    wait_done(100);
    repeat (2) tick();
    check("t2_done_pulses", done_cnt - d0, 32'd1);
    check("t2_pending_at_done", sb_at_done, 32'd1);
    wait_empty(50);
    check("t2_results", results - r0, 32'd4);

    // Backpressure: FIFO fills, issue stops at 16, then drains in order.
    r_ready = 1'b0;
    r0 = results; a0 = accepted;
    start_job(8'd20, {$urandom, $urandom}, 1'b0);
    fork
      send_vectors(20, 1'b0, 1'b1, '0);
      begin
        repeat (40) tick();
        check("t3_accepts_at_full", accepted - a0, 32'd16);
        check("t3_a_ready_low", 32'(a_ready), 32'd0);
        check("t3_r_valid", 32'(r_valid), 32'd1);
        check("t3_no_pop", results - r0, 32'd0);
        r_ready = 1'b1;
      end
    join
    wait_done(200);
    repeat (2) tick();
    wait_empty(100);
    check("t3_results", results - r0, 32'd20);

    // Bubbled stream with distinct vectors.
    r0 = results;
    start_job(8'd6, {$urandom, $urandom}, 1'b0);
    send_vectors(6, 1'b1, 1'b1, '0);
    wait_done(100);
    repeat (2) tick();
    wait_empty(50);
    check("t4_results", results - r0, 32'd6);

    // Empty job.
    d0 = done_cnt; v0 = rv_cycles;
    start_job(8'd0, {$urandom, $urandom}, 1'b0);
    wait_done(50);
    repeat (10) tick();
    check("t5_done_pulses", done_cnt - d0, 32'd1);
    check("t5_no_r_valid", rv_cycles, v0);

    // Start held through the job; error flag on the second result only.
    err_idx = 1;
    d0 = done_cnt; r0 = results; a0 = accepted;
    start_job(8'd3, {$urandom, $urandom}, 1'b1);
    send_vectors(3, 1'b0, 1'b1, '0);
    wait_done(100);
    start = 1'b0;
    repeat (5) tick();
    check("t6_busy_after", 32'(busy), 32'd0);
    check("t6_done_pulses", done_cnt - d0, 32'd1);
    check("t6_accepts", accepted - a0, 32'd3);
    wait_empty(50);
    err_idx = 999;
    check("t6_results", results - r0, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
